// File: rtl/tx_slot_writer_if.sv
// tx_slot_writer_if: descriptor, payload stream and slot-memory write bus.
//   frm_*  : frame descriptor handshake (host -> writer)
//   in_*   : 16-bit payload word handshake (host -> writer)
//   slot_* : slot memory write port (writer -> memory)
interface tx_slot_writer_if;
  logic        frm_valid;
  logic        frm_ready;
  logic [15:0] frm_len;
  logic [63:0] frm_timestamp;
  logic [31:0] frm_hash;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] slot_tx_eth_data;
  logic [1:0]  slot_tx_eth_byte_en;
  logic [13:0] slot_tx_eth_addr;
  logic        slot_tx_eth_wr_en;
  modport slave (
    input  frm_valid, frm_len, frm_timestamp, frm_hash, in_data, in_valid,
    output frm_ready, in_ready, slot_tx_eth_data, slot_tx_eth_byte_en, slot_tx_eth_addr, slot_tx_eth_wr_en
  );
  modport master (
    output frm_valid, frm_len, frm_timestamp, frm_hash, in_data, in_valid,
    input  frm_ready, in_ready, slot_tx_eth_data, slot_tx_eth_byte_en, slot_tx_eth_addr, slot_tx_eth_wr_en
  );
endinterface

// File: rtl/tx_slot_writer.sv
// tx_slot_writer: writes one header+payload slot record per frame into a 16K-word ring.
//   sys_clk/sys_rst_n : clock, synchronous active-low reset
//   bus               : descriptor, payload and slot-memory write signals
//   mem_rd_ptr        : consumer read pointer; mem_wr_ptr: committed write pointer
//   err_len           : pulse on rejected frame; frames_ok/frames_drop: wrapping counters
module tx_slot_writer #(
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  tx_slot_writer_if.slave       bus,
  input  logic [13:0]           mem_rd_ptr,
  output logic [13:0]           mem_wr_ptr,
  output logic                  err_len,
  output logic [31:0]           frames_ok,
  output logic [31:0]           frames_drop
);
  localparam int HDR_WORDS = 7;
  typedef enum logic [2:0] {IDLE, WAIT_SPACE, HDR, DATA, COMMIT, DROP} state_t;
  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [63:0] ts_q, ts_d;
  logic [31:0] hash_q, hash_d;
  logic [13:0] base_q, base_d, ptr_q, ptr_d, addr_q, addr_d;
  logic [14:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  be_q, be_d;
  logic        we_q, we_d, err_q, err_d;
  logic [31:0] ok_q, ok_d, drop_q, drop_d;
  logic [14:0] nw_in, nw;
  logic [15:0] need, hdr;
  logic [13:0] free;
  logic        frm_hs, in_hs, bad_in, last;
  assign nw_in  = bus.frm_len[15:1] + 15'(bus.frm_len[0]);
  assign nw     = len_q[15:1] + 15'(len_q[0]);
  assign need   = 16'(HDR_WORDS) + {1'b0, nw};
  // one word stays empty so a full ring never looks empty
  assign free   = mem_rd_ptr - ptr_q - 14'd1;
  assign frm_hs = bus.frm_valid && bus.frm_ready;
  assign in_hs  = bus.in_valid && bus.in_ready;
  assign bad_in = bus.frm_len == 16'd0 || {16'd0, bus.frm_len} > MAX_FRAME_LEN;
  assign last   = cnt_q == nw - 15'd1;
  assign hdr    = cnt_q[2:0] == 3'd0 ? len_q :
                  cnt_q[2:0] == 3'd1 ? ts_q[63:48] :
                  cnt_q[2:0] == 3'd2 ? ts_q[47:32] :
                  cnt_q[2:0] == 3'd3 ? ts_q[31:16] :
                  cnt_q[2:0] == 3'd4 ? ts_q[15:0] :
                  cnt_q[2:0] == 3'd5 ? hash_q[31:16] : hash_q[15:0];
  assign bus.frm_ready           = state_q == IDLE;
  assign bus.in_ready            = state_q == DATA || state_q == DROP;
  assign bus.slot_tx_eth_data    = data_q;
  assign bus.slot_tx_eth_byte_en = be_q;
  assign bus.slot_tx_eth_addr    = addr_q;
  assign bus.slot_tx_eth_wr_en   = we_q;
  assign mem_wr_ptr              = ptr_q;
  assign err_len                 = err_q;
  assign frames_ok               = ok_q;
  assign frames_drop             = drop_q;
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      ts_q    <= '0;
      hash_q  <= '0;
      base_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      ok_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ts_q    <= ts_d;
      hash_q  <= hash_d;
      base_q  <= base_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
      drop_q  <= drop_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (frm_hs) state_d = !bad_in ? WAIT_SPACE : nw_in == 15'd0 ? IDLE : DROP;
      WAIT_SPACE: if ({2'b0, free} >= need) state_d = HDR;
      HDR:        if (cnt_q == 15'(HDR_WORDS - 1)) state_d = DATA;
      DATA:       if (in_hs && last) state_d = COMMIT;
      COMMIT:     state_d = IDLE;
      DROP:       if (in_hs && last) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    len_d  = len_q;
    ts_d   = ts_q;
    hash_d = hash_q;
    base_d = base_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    be_d   = be_q;
    we_d   = 1'b0;
    err_d  = 1'b0;
    ok_d   = ok_q;
    drop_d = drop_q;
    case (state_q)
      IDLE: if (frm_hs) begin
        len_d  = bus.frm_len;
        ts_d   = bus.frm_timestamp;
        hash_d = bus.frm_hash;
        base_d = ptr_q;
        cnt_d  = '0;
        err_d  = bad_in;
        drop_d = drop_q + 32'(bad_in);
      end
      HDR: begin
        we_d   = 1'b1;
        addr_d = base_q + cnt_q[13:0];
        data_d = hdr;
        be_d   = 2'b11;
        cnt_d  = cnt_q == 15'(HDR_WORDS - 1) ? '0 : cnt_q + 15'd1;
      end
      DATA: if (in_hs) begin
        we_d   = 1'b1;
        addr_d = base_q + 14'(HDR_WORDS) + cnt_q[13:0];
        data_d = bus.in_data;
        be_d   = last && len_q[0] ? 2'b10 : 2'b11;
        cnt_d  = cnt_q + 15'd1;
      end
      COMMIT: begin
        ptr_d = base_q + need[13:0];
        ok_d  = ok_q + 32'd1;
      end
      DROP: if (in_hs) cnt_d = cnt_q + 15'd1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_tx_slot_writer.sv
// tb_tx_slot_writer: directed bench for tx_slot_writer with a slot-memory model.
module tb_tx_slot_writer;
  logic        clk;
  logic        rst_n;
  logic [13:0] mem_rd_ptr;
  logic [13:0] mem_wr_ptr;
  logic        err_len;
  logic [31:0] frames_ok;
  logic [31:0] frames_drop;
  logic [15:0] mem [0:16383];
  logic [1:0]  be_mem [0:16383];
  int          wr_cnt;
  int          err_pulses;
  int          vectors;
  int          miscompares;
  localparam logic [63:0] TS = 64'h0123_4567_89AB_CDEF;
  localparam logic [31:0] HS = 32'hDEAD_BEEF;
  tx_slot_writer_if bus ();
  tx_slot_writer #(.MAX_FRAME_LEN(1518)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus), .mem_rd_ptr(mem_rd_ptr),
    .mem_wr_ptr(mem_wr_ptr), .err_len(err_len), .frames_ok(frames_ok), .frames_drop(frames_drop)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.slot_tx_eth_wr_en === 1'b1) begin
      if (bus.slot_tx_eth_byte_en[1]) mem[bus.slot_tx_eth_addr][15:8] <= bus.slot_tx_eth_data[15:8];
      if (bus.slot_tx_eth_byte_en[0]) mem[bus.slot_tx_eth_addr][7:0] <= bus.slot_tx_eth_data[7:0];
      be_mem[bus.slot_tx_eth_addr] <= bus.slot_tx_eth_byte_en;
      wr_cnt <= wr_cnt + 1;
    end
    if (err_len === 1'b1) err_pulses <= err_pulses + 1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_desc(input logic [15:0] len);
    int t = 0;
    bus.frm_valid = 1'b1;
    bus.frm_len = len;
    bus.frm_timestamp = TS;
    bus.frm_hash = HS;
    while (bus.frm_ready !== 1'b1 && t < 1000) begin
      tick();
      t++;
    end
    chk("desc_ready", 64'(bus.frm_ready), 1);
    tick();
    bus.frm_valid = 1'b0;
  endtask
  task automatic send_payload(input int n, input logic [15:0] base, input bit gap);
    int acc = 0;
    int t = 0;
    bit phase = 1'b1;
    bit hs;
    while (acc < n && t < 20000) begin
      bus.in_valid = gap ? phase : 1'b1;
      bus.in_data = base + 16'(acc);
      hs = bus.in_valid && bus.in_ready === 1'b1;
      phase = ~phase;
      tick();
      if (hs) acc++;
      t++;
    end
    bus.in_valid = 1'b0;
    chk("payload_accepted", 64'(acc), 64'(n));
  endtask
  task automatic expect_commit(input logic [13:0] a, input logic [1:0] be, input logic [13:0] oldp, input logic [13:0] newp);
    chk("last_wr_en", 64'(bus.slot_tx_eth_wr_en), 1);
    chk("last_addr", 64'(bus.slot_tx_eth_addr), 64'(a));
    chk("last_be", 64'(bus.slot_tx_eth_byte_en), 64'(be));
    chk("ptr_before_commit", 64'(mem_wr_ptr), 64'(oldp));
    tick();
    chk("ptr_after_commit", 64'(mem_wr_ptr), 64'(newp));
    chk("wr_en_after_commit", 64'(bus.slot_tx_eth_wr_en), 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    int w0;
    vectors = 0;
    miscompares = 0;
    wr_cnt = 0;
    err_pulses = 0;
    rst_n = 1'b0;
    mem_rd_ptr = '0;
    bus.frm_valid = 1'b0;
    bus.frm_len = '0;
    bus.frm_timestamp = '0;
    bus.frm_hash = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_wr_ptr", 64'(mem_wr_ptr), 0);
    chk("rst_ok", 64'(frames_ok), 0);
    chk("rst_drop", 64'(frames_drop), 0);
    chk("rst_wr_en", 64'(bus.slot_tx_eth_wr_en), 0);
    chk("rst_addr", 64'(bus.slot_tx_eth_addr), 0);
    chk("rst_data", 64'(bus.slot_tx_eth_data), 0);
    chk("rst_be", 64'(bus.slot_tx_eth_byte_en), 0);
    chk("rst_err", 64'(err_len), 0);
    chk("rst_frm_ready", 64'(bus.frm_ready), 1);
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    // len=60 at wr=0
    send_desc(16'd60);
    send_payload(30, 16'h0001, 1'b0);
    expect_commit(14'd36, 2'b11, 14'd0, 14'd37);
    chk("t1_ok", 64'(frames_ok), 1);
    chk("t1_hdr_len", 64'(mem[0]), 60);
    chk("t1_ts3", 64'(mem[1]), 64'h0123);
    chk("t1_ts2", 64'(mem[2]), 64'h4567);
    chk("t1_ts1", 64'(mem[3]), 64'h89AB);
    chk("t1_ts0", 64'(mem[4]), 64'hCDEF);
    chk("t1_hash1", 64'(mem[5]), 64'hDEAD);
    chk("t1_hash0", 64'(mem[6]), 64'hBEEF);
    for (int k = 0; k < 30; k++) chk("t1_payload", 64'(mem[7+k]), 64'(k + 1));
    for (int k = 0; k < 37; k++) chk("t1_be", 64'(be_mem[k]), 3);
    // len=61 at wr=0: odd tail
    do_reset();
    send_desc(16'd61);
    send_payload(31, 16'h0100, 1'b0);
    expect_commit(14'd37, 2'b10, 14'd0, 14'd38);
    chk("t2_len", 64'(mem[0]), 61);
    chk("t2_prev_word", 64'(mem[36]), 64'h011D);
    chk("t2_tail_hi", 64'(mem[37][15:8]), 64'h01);
    chk("t2_tail_be", 64'(be_mem[37]), 2);
    // rejected frames
    w0 = wr_cnt;
    send_desc(16'd0);
    chk("t3_err0", 64'(err_len), 1);
    chk("t3_idle0", 64'(bus.frm_ready), 1);
    send_desc(16'd2000);
    chk("t3_err1", 64'(err_len), 1);
    chk("t3_drop_rdy", 64'(bus.in_ready), 1);
    send_payload(1000, 16'h4000, 1'b0);
    chk("t3_in_ready_done", 64'(bus.in_ready), 0);
    chk("t3_frm_ready", 64'(bus.frm_ready), 1);
    chk("t3_drop_cnt", 64'(frames_drop), 2);
    chk("t3_err_pulses", 64'(err_pulses), 2);
    chk("t3_no_writes", 64'(wr_cnt), 64'(w0));
    chk("t3_ptr", 64'(mem_wr_ptr), 38);
    // len=64 with gaps at wr=38
    w0 = wr_cnt;
    send_desc(16'd64);
    send_payload(32, 16'h0200, 1'b1);
    expect_commit(14'd76, 2'b11, 14'd38, 14'd77);
    chk("t4_writes", 64'(wr_cnt - w0), 39);
    for (int k = 0; k < 32; k++) chk("t4_payload", 64'(mem[45+k]), 64'(32'h0200 + k));
    chk("t4_ok", 64'(frames_ok), 2);
    // reset mid-frame on DATA word 10
    send_desc(16'd60);
    send_payload(10, 16'h0500, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = 16'h050A;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    chk("t5_idle", 64'(bus.frm_ready), 1);
    chk("t5_in_ready", 64'(bus.in_ready), 0);
    chk("t5_ptr", 64'(mem_wr_ptr), 0);
    chk("t5_wr_en", 64'(bus.slot_tx_eth_wr_en), 0);
    chk("t5_ok", 64'(frames_ok), 0);
    chk("t5_drop", 64'(frames_drop), 0);
    send_desc(16'd60);
    send_payload(30, 16'h0600, 1'b0);
    expect_commit(14'd36, 2'b11, 14'd0, 14'd37);
    chk("t5_ok_after", 64'(frames_ok), 1);
    // advance to wr=16370: 21 x need 766, then need 247
    for (int i = 0; i < 21; i++) begin
      send_desc(16'd1518);
      send_payload(759, 16'h1000, 1'b0);
      tick();
    end
    send_desc(16'd480);
    send_payload(240, 16'h2000, 1'b0);
    tick();
    chk("fill_ptr", 64'(mem_wr_ptr), 16370);
    chk("fill_ok", 64'(frames_ok), 23);
    // space stall and wrap
    mem_rd_ptr = 14'd10;
    w0 = wr_cnt;
    send_desc(16'd60);
    for (int i = 0; i < 6; i++) begin
      chk("t6_stall_in_ready", 64'(bus.in_ready), 0);
      chk("t6_stall_frm_ready", 64'(bus.frm_ready), 0);
      tick();
    end
    chk("t6_stall_writes", 64'(wr_cnt), 64'(w0));
    mem_rd_ptr = 14'd40;
    send_payload(30, 16'h0300, 1'b0);
    expect_commit(14'd22, 2'b11, 14'd16370, 14'd23);
    chk("t6_hdr", 64'(mem[16370]), 60);
    chk("t6_pre_wrap", 64'(mem[16383]), 64'h0306);
    chk("t6_post_wrap", 64'(mem[0]), 64'h0307);
    chk("t6_last", 64'(mem[22]), 64'h031D);
    chk("t6_writes", 64'(wr_cnt - w0), 37);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
